// File: rtl/rggen_backdoor_access_mux.sv
// Merges a frontdoor and a backdoor register access port onto one register port.
// Ports: i_clk/i_rst; i_fd_* / o_fd_* frontdoor request and completion;
//        i_bd_* / o_bd_* backdoor request, completion, value copy and pending flag;
//        o_reg_* / i_reg_* access to the register field logic.
module rggen_backdoor_access_mux #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_FD_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fd_valid,
    input  logic                  i_fd_write,
    input  logic [DATA_WIDTH-1:0] i_fd_mask,
    input  logic [DATA_WIDTH-1:0] i_fd_write_data,
    output logic                  o_fd_ready,
    output logic [DATA_WIDTH-1:0] o_fd_read_data,
    input  logic                  i_bd_valid,
    input  logic [DATA_WIDTH-1:0] i_bd_read_mask,
    input  logic [DATA_WIDTH-1:0] i_bd_write_mask,
    input  logic [DATA_WIDTH-1:0] i_bd_write_data,
    output logic                  o_bd_ready,
    output logic [DATA_WIDTH-1:0] o_bd_read_data,
    output logic [DATA_WIDTH-1:0] o_bd_value,
    output logic                  o_bd_pending,
    output logic                  o_reg_valid,
    output logic [DATA_WIDTH-1:0] o_reg_read_mask,
    output logic [DATA_WIDTH-1:0] o_reg_write_mask,
    output logic [DATA_WIDTH-1:0] o_reg_write_data,
    input  logic                  i_reg_ready,
    input  logic [DATA_WIDTH-1:0] i_reg_read_data,
    input  logic [DATA_WIDTH-1:0] i_reg_value
);

    // A zero burst limit still needs a one-bit counter; it simply never moves.
    localparam int CNT_W = (MAX_FD_BURST > 0) ? $clog2(MAX_FD_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FD_BURST);

    typedef enum logic [1:0] {
        IDLE,
        FD_ACTIVE,
        BD_ACTIVE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             resp_bd;
    logic [CNT_W-1:0] wait_cnt;
    logic             fd_grant;
    logic             bd_grant;
    logic             done;

    always_comb begin
        state_next = state;
        fd_grant   = 1'b0;
        bd_grant   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_bd_valid && (wait_cnt == CNT_MAX || !i_fd_valid)) begin
                    bd_grant   = 1'b1;
                    state_next = BD_ACTIVE;
                end else if (i_fd_valid) begin
                    fd_grant   = 1'b1;
                    state_next = FD_ACTIVE;
                end
            end
            FD_ACTIVE: begin
                if (i_reg_ready) begin
                    state_next = RESP;
                end
            end
            BD_ACTIVE: begin
                if (i_reg_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign done         = i_reg_ready &&
                          (state == FD_ACTIVE || state == BD_ACTIVE);
    assign o_reg_valid  = (state == FD_ACTIVE) || (state == BD_ACTIVE);
    assign o_fd_ready   = (state == RESP) && !resp_bd;
    assign o_bd_ready   = (state == RESP) && resp_bd;
    assign o_bd_pending = i_bd_valid &&
                          !((state == BD_ACTIVE) || (state == RESP && resp_bd));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            resp_bd          <= 1'b0;
            wait_cnt         <= '0;
            o_reg_read_mask  <= '0;
            o_reg_write_mask <= '0;
            o_reg_write_data <= '0;
            o_fd_read_data   <= '0;
            o_bd_read_data   <= '0;
            o_bd_value       <= '0;
        end else begin
            state      <= state_next;
            o_bd_value <= i_reg_value;

            if (bd_grant) begin
                o_reg_read_mask  <= i_bd_read_mask;
                o_reg_write_mask <= i_bd_write_mask;
                o_reg_write_data <= i_bd_write_data;
            end else if (fd_grant) begin
                o_reg_read_mask  <= i_fd_write ? '0 : i_fd_mask;
                o_reg_write_mask <= i_fd_write ? i_fd_mask : '0;
                o_reg_write_data <= i_fd_write ? i_fd_write_data : '0;
            end

            if (done) begin
                resp_bd <= (state == BD_ACTIVE);
                if (state == BD_ACTIVE) begin
                    o_bd_read_data <= i_reg_read_data;
                end else begin
                    o_fd_read_data <= i_reg_read_data;
                end
            end

            // Counts frontdoor wins taken while the backdoor was waiting.
            if (bd_grant) begin
                wait_cnt <= '0;
            end else if (fd_grant && i_bd_valid && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rggen_backdoor_access_mux.sv
// Scoreboard bench for rggen_backdoor_access_mux: random requesters and register,
// an abstract arbitration model filling expectation queues, and a negedge monitor.
module tb_rggen_backdoor_access_mux;

    localparam int DW   = 32;
    localparam int MAXB = 4;

    typedef struct {
        logic [DW-1:0] rm;
        logic [DW-1:0] wm;
        logic [DW-1:0] wd;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          fd_valid = 1'b0, fd_write = 1'b0;
    logic [DW-1:0] fd_mask = '0, fd_wdata = '0;
    logic          fd_ready;
    logic [DW-1:0] fd_rdata;
    logic          bd_valid = 1'b0;
    logic [DW-1:0] bd_rmask = '0, bd_wmask = '0, bd_wdata = '0;
    logic          bd_ready, bd_pending;
    logic [DW-1:0] bd_rdata, bd_value;
    logic          reg_valid;
    logic [DW-1:0] reg_rmask, reg_wmask, reg_wdata;
    logic          reg_ready = 1'b0;
    logic [DW-1:0] reg_rdata = '0, reg_value = '0;

    logic          fd0_valid = 1'b0, bd0_valid = 1'b0;
    logic          fd0_ready, bd0_ready, bd0_pending, reg_valid0;
    logic [DW-1:0] fd0_rdata, bd0_rdata, bd0_value;
    logic [DW-1:0] reg_rmask0, reg_wmask0, reg_wdata0;

    rggen_backdoor_access_mux #(.DATA_WIDTH(DW), .MAX_FD_BURST(MAXB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_fd_valid(fd_valid), .i_fd_write(fd_write),
        .i_fd_mask(fd_mask), .i_fd_write_data(fd_wdata),
        .o_fd_ready(fd_ready), .o_fd_read_data(fd_rdata),
        .i_bd_valid(bd_valid), .i_bd_read_mask(bd_rmask),
        .i_bd_write_mask(bd_wmask), .i_bd_write_data(bd_wdata),
        .o_bd_ready(bd_ready), .o_bd_read_data(bd_rdata),
        .o_bd_value(bd_value), .o_bd_pending(bd_pending),
        .o_reg_valid(reg_valid), .o_reg_read_mask(reg_rmask),
        .o_reg_write_mask(reg_wmask), .o_reg_write_data(reg_wdata),
        .i_reg_ready(reg_ready), .i_reg_read_data(reg_rdata),
        .i_reg_value(reg_value)
    );

    // Strict-priority variant; its register answers in the first valid cycle.
    rggen_backdoor_access_mux #(.DATA_WIDTH(DW), .MAX_FD_BURST(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_fd_valid(fd0_valid), .i_fd_write(fd_write),
        .i_fd_mask(fd_mask), .i_fd_write_data(fd_wdata),
        .o_fd_ready(fd0_ready), .o_fd_read_data(fd0_rdata),
        .i_bd_valid(bd0_valid), .i_bd_read_mask(bd_rmask),
        .i_bd_write_mask(bd_wmask), .i_bd_write_data(bd_wdata),
        .o_bd_ready(bd0_ready), .o_bd_read_data(bd0_rdata),
        .o_bd_value(bd0_value), .o_bd_pending(bd0_pending),
        .o_reg_valid(reg_valid0), .o_reg_read_mask(reg_rmask0),
        .o_reg_write_mask(reg_wmask0), .o_reg_write_data(reg_wdata0),
        .i_reg_ready(reg_valid0), .i_reg_read_data(reg_rdata),
        .i_reg_value(reg_value)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an event, required none at %0t", nm, $time);
    endtask

    // Reference model state: 0 idle, 1 access in flight, 2 response cycle.
    int            phase    = 0;
    bit            owner_bd = 1'b0;
    int            streak   = 0;
    acc_t          exp_acc[$];
    logic [DW-1:0] exp_fd[$];
    logic [DW-1:0] exp_bd[$];
    logic [DW-1:0] exp_value = '0;

    bit fd_on = 1'b0, bd_on = 1'b0, burst = 1'b0, stall = 1'b0;
    bit dut0_on = 1'b0;
    int bd0_cnt = 0;

    // Model update from the inputs seen at this edge, then new stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase = 0;
                owner_bd = 1'b0;
                streak = 0;
                exp_acc.delete();
                exp_fd.delete();
                exp_bd.delete();
            end else begin
                case (phase)
                    0: begin
                        if (bd_valid && (streak >= MAXB || !fd_valid)) begin
                            exp_acc.push_back('{bd_rmask, bd_wmask, bd_wdata});
                            owner_bd = 1'b1;
                            streak = 0;
                            phase = 1;
                        end else if (fd_valid) begin
                            if (fd_write)
                                exp_acc.push_back('{'0, fd_mask, fd_wdata});
                            else
                                exp_acc.push_back('{fd_mask, '0, '0});
                            owner_bd = 1'b0;
                            if (bd_valid && streak < MAXB) streak++;
                            phase = 1;
                        end
                    end
                    1: begin
                        if (reg_ready) begin
                            if (owner_bd) exp_bd.push_back(reg_rdata);
                            else exp_fd.push_back(reg_rdata);
                            phase = 2;
                        end
                    end
                    default: phase = 0;
                endcase
            end
            exp_value = rst ? '0 : reg_value;

            if (fd_valid && fd_ready) fd_valid = 1'b0;
            if (fd_valid && $urandom_range(0, 2) == 0) begin
                fd_write = 1'($urandom_range(0, 1));
                fd_mask  = $urandom;
                fd_wdata = $urandom;
            end
            if (!fd_valid && fd_on && (burst || $urandom_range(0, 3) == 0)) begin
                fd_valid = 1'b1;
                fd_write = 1'($urandom_range(0, 1));
                fd_mask  = $urandom;
                fd_wdata = $urandom;
            end

            if (bd_valid && bd_ready) bd_valid = 1'b0;
            if (!bd_valid && bd_on && (burst || $urandom_range(0, 5) == 0)) begin
                bd_valid = 1'b1;
                bd_rmask = $urandom;
                bd_wmask = $urandom;
                bd_wdata = $urandom;
            end

            if (stall) reg_ready = 1'b0;
            else if (reg_valid) reg_ready = ($urandom_range(0, 2) == 0);
            else reg_ready = ($urandom_range(0, 4) == 0);
            reg_rdata = $urandom;
            reg_value = $urandom;
        end
    end

    acc_t cur = '{'0, '0, '0};
    bit   prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            chk("bd_value", bd_value, exp_value);
            chk("bd_pending", 32'(bd_pending),
                32'(bd_valid && !(phase != 0 && owner_bd)));
            chk("reg_valid", 32'(reg_valid), 32'(phase == 1));
            if (reg_valid) begin
                if (!prev_valid) begin
                    if (exp_acc.size() == 0) unexpected("grant");
                    else cur = exp_acc.pop_front();
                end
                chk("reg_read_mask", reg_rmask, cur.rm);
                chk("reg_write_mask", reg_wmask, cur.wm);
                chk("reg_write_data", reg_wdata, cur.wd);
            end
            prev_valid = reg_valid;
            if (fd_ready) begin
                if (exp_fd.size() == 0) unexpected("fd_ready");
                else chk("fd_read_data", fd_rdata, exp_fd.pop_front());
            end
            if (bd_ready) begin
                if (exp_bd.size() == 0) unexpected("bd_ready");
                else chk("bd_read_data", bd_rdata, exp_bd.pop_front());
            end
            if (dut0_on) begin
                if (fd0_ready) unexpected("strict_fd_ready");
                if (bd0_ready) bd0_cnt++;
                if (reg_valid0) begin
                    chk("strict_write_mask", reg_wmask0, bd_wmask);
                    chk("strict_read_mask", reg_rmask0, bd_rmask);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        cycles(3);
        chk("rst_reg_valid", 32'(reg_valid), 32'(0));
        chk("rst_fd_ready", 32'(fd_ready), 32'(0));
        chk("rst_bd_ready", 32'(bd_ready), 32'(0));
        chk("rst_read_mask", reg_rmask, '0);
        chk("rst_write_mask", reg_wmask, '0);
        chk("rst_write_data", reg_wdata, '0);
        chk("rst_fd_read_data", fd_rdata, '0);
        chk("rst_bd_read_data", bd_rdata, '0);
        chk("rst_bd_value", bd_value, '0);
        chk("rst_bd_pending", 32'(bd_pending), 32'(0));
        rst = 1'b0;

        fd_on = 1'b1;
        bd_on = 1'b1;
        cycles(600);
        burst = 1'b1;
        cycles(200);
        burst = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phase == 1 && !owner_bd) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) unexpected("no_fd_access_for_stall");
        stall = 1'b1;
        cycles(12);
        stall = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phase == 1 && !owner_bd) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) unexpected("no_fd_access_for_reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_active_reg_valid", 32'(reg_valid), 32'(0));
        chk("rst_active_fd_ready", 32'(fd_ready), 32'(0));
        cycles(300);

        fd_on = 1'b0;
        bd_on = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!fd_valid && !bd_valid && phase == 0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) unexpected("drain_timeout");
        cycles(2);
        chk("left_acc", 32'(exp_acc.size()), 32'(0));
        chk("left_fd", 32'(exp_fd.size()), 32'(0));
        chk("left_bd", 32'(exp_bd.size()), 32'(0));

        dut0_on = 1'b1;
        fd0_valid = 1'b1;
        bd0_valid = 1'b1;
        cycles(30);
        dut0_on = 1'b0;
        fd0_valid = 1'b0;
        bd0_valid = 1'b0;
        chk("strict_bd_grants", 32'(bd0_cnt >= 8), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
